mult_operand_feeder: RTL and testbench
======================================

# mult_operand_feeder

Upstream sequencer for the shift-add multiplier (datapath + controller pair). Accepts 8-bit operand pairs on a valid/ready handshake into a 2-deep FIFO and replays each pair onto the multiplier's shared `data_in` bus in the required order: reset pulse, start, A, then B. It waits for `done`, captures the 16-bit product and presents it on a valid/ready output port. Zero operands bypass the multiplier; a watchdog bounds every transaction.

## Interface
- `W`, 8: operand width; product is 2*W.
- `DEPTH`, 2: operand FIFO entries (power of two).
- `TIMEOUT`, 300: max cycles in WAIT before abort.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO not full.
- `in_a`, `in_b` in W each: multiplicand, multiplier.
- `mult_reset` out 1: active-high reset to multiplier controller.
- `mult_start` out 1: start to multiplier controller.
- `mult_data` out W: drives multiplier `data_in`.
- `mult_done` in 1: multiplier done (level).
- `mult_prod` in 2W: multiplier product register.
- `out_valid` out 1: product valid.
- `out_ready` in 1: consumer accepts product.
- `out_prod` out 2W: product.
- `out_err` out 1: product was aborted by watchdog (qualifies `out_valid`).

## Operation
- FIFO: push when `in_valid && in_ready`; `in_ready = (count != DEPTH)`. Pop happens on entry to CAP or ZERO. Push and pop in the same cycle are legal when count is 1; count stays unchanged.
- FSM states: IDLE, MRST, START, LDA, LDB, WAIT, CAP, ZERO, HOLD.
- IDLE: FIFO non-empty and `!out_valid`. If the head has `a==0 || b==0`, go to ZERO; otherwise go to MRST.
- MRST: `mult_reset=1` for 1 cycle, then START.
- START: `mult_start=1` for 1 cycle, then LDA.
- LDA: `mult_data=a` for 1 cycle, then LDB.
- LDB: `mult_data=b` for 1 cycle, then WAIT.
- WAIT: clear the watchdog on entry. If `mult_done`, go to CAP. If the watchdog reaches TIMEOUT, go to CAP with abort.
- CAP: `out_prod <= abort ? 0 : mult_prod`; `out_err <= abort`; `out_valid <= 1`; pop; then HOLD.
- ZERO: `out_prod <= 0`, `out_err <= 0`, `out_valid <= 1`, pop; then HOLD. `mult_*` stay idle.
- HOLD: wait until `out_valid && out_ready` (output cleared that cycle), then IDLE.
- `mult_data = 0` outside LDA/LDB.
- `mult_start = 0` outside START.
- `mult_reset = 0` outside MRST.
- Product width is exactly 2W. No truncation occurs; 255*255 = 65025.
- Reset (async, any state): FSM to IDLE, FIFO emptied, `in_ready=1` (after deassertion), `out_valid=0`, `out_prod=0`, `out_err=0`, `mult_reset=0`, `mult_start=0`, `mult_data=0`, watchdog=0.
- Reset mid-transaction drops the in-flight pair and all queued pairs. No product is emitted.

## Timing
- All outputs are registered.
- Pop to LDB: the pair leaves the bus after 4 cycles (MRST, START, LDA, LDB), one cycle each, strictly consecutive.
- `mult_done` is sampled in WAIT only. `done` asserted before WAIT is ignored.
- Product latency from IDLE exit: 4 + (WAIT cycles) + 1 to `out_valid`.
- Zero bypass: `out_valid` rises 2 cycles after the pair reaches the FIFO head in IDLE.
- Back-to-back transactions: IDLE is revisited for 1 cycle between pairs.
- Watchdog: 9-bit counter.
- Abort asserts `out_valid` at WAIT-entry + TIMEOUT + 1.
- `out_valid` holds with a stable `out_prod`/`out_err` until accepted. Backpressure stalls the FSM in HOLD while the FIFO continues to accept input until full.

## Test plan
- Single pair a=8, b=9 with `out_ready=1` -> `mult_reset`, `mult_start`, `mult_data`=8, `mult_data`=9 on 4 consecutive cycles; `out_prod`=72, `out_err`=0, `out_valid` for 1 cycle.
- Zero bypass: a=0, b=200, then a=17, b=0 -> two products of 0. `mult_start` never asserts.
- Full/backpressure: `out_ready=0`, push 3 pairs (3,4), (5,6), (7,8) -> `in_ready` low after the third pair is accepted (first in HOLD, two queued). Release `out_ready` -> products 12, 30, 56 in order, no loss.
- Max operands: a=255, b=255 -> `out_prod`=65025.
- Watchdog: `mult_done` tied 0 -> after TIMEOUT cycles in WAIT, `out_valid`=1, `out_err`=1, `out_prod`=0. The next pair then processes normally.
- Reset mid-operation: assert `reset`=0 during WAIT with 1 pair queued -> all outputs go to their reset values immediately. No `out_valid` appears after release until a new pair is pushed.

Source files
------------

// File: rtl/mult_operand_feeder_if.sv
// Handshake and multiplier-bus signals between the operand feeder and its neighbours.
// master is the feeder's view; slave is the producer/multiplier/consumer side.
interface mult_operand_feeder_if #(parameter int W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           mult_reset;
    logic           mult_start;
    logic [W-1:0]   mult_data;
    logic           mult_done;
    logic [2*W-1:0] mult_prod;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_prod;
    logic           out_err;

    modport master (
        input  in_valid, in_a, in_b, mult_done, mult_prod, out_ready,
        output in_ready, mult_reset, mult_start, mult_data, out_valid, out_prod, out_err
    );
    modport slave (
        output in_valid, in_a, in_b, mult_done, mult_prod, out_ready,
        input  in_ready, mult_reset, mult_start, mult_data, out_valid, out_prod, out_err
    );
endinterface

// File: rtl/mult_operand_feeder.sv
// Queues operand pairs and replays each onto the shift-add multiplier bus
// (reset, start, A, B), then returns the product with a watchdog-bounded wait.
module mult_operand_feeder #(
    parameter int W       = 8,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 300
) (
    input logic                   clk,
    input logic                   reset,
    mult_operand_feeder_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    typedef enum logic [3:0] {IDLE, MRST, START, LDA, LDB, WAIT, CAP, ZERO, HOLD} state_t;

    state_t         state, state_nx;
    pair_t          mem [DEPTH];
    pair_t          head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [8:0]     wdog;
    logic           abort, timeout;
    logic           push, pop, empty;

    logic           mult_reset_nx, mult_start_nx, out_valid_nx, out_err_nx;
    logic [W-1:0]   mult_data_nx;
    logic [2*W-1:0] out_prod_nx;

    assign head         = mem[rd_ptr];
    assign empty        = (count == '0);
    assign bus.in_ready = (count != CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    // CAP and ZERO last exactly one cycle, so entering them is the pop point
    assign pop          = (state_nx == CAP) || (state_nx == ZERO);
    assign timeout      = (state == WAIT) && !bus.mult_done && (wdog == 9'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (!empty && !bus.out_valid)
                       state_nx = (head.a == '0 || head.b == '0) ? ZERO : MRST;
            MRST:  state_nx = START;
            START: state_nx = LDA;
            LDA:   state_nx = LDB;
            LDB:   state_nx = WAIT;
            WAIT:  if (bus.mult_done || timeout) state_nx = CAP;
            CAP:   state_nx = HOLD;
            ZERO:  state_nx = HOLD;
            HOLD:  if (bus.out_valid && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus outputs follow the next state so they are registered yet line up with it
    always_comb begin
        mult_reset_nx = (state_nx == MRST);
        mult_start_nx = (state_nx == START);
        mult_data_nx  = '0;
        if (state_nx == LDA) mult_data_nx = head.a;
        if (state_nx == LDB) mult_data_nx = head.b;
        out_valid_nx = bus.out_valid;
        out_prod_nx  = bus.out_prod;
        out_err_nx   = bus.out_err;
        case (state)
            CAP: begin
                out_valid_nx = 1'b1;
                out_prod_nx  = abort ? '0 : bus.mult_prod;
                out_err_nx   = abort;
            end
            ZERO: begin
                out_valid_nx = 1'b1;
                out_prod_nx  = '0;
                out_err_nx   = 1'b0;
            end
            HOLD: if (bus.out_valid && bus.out_ready) out_valid_nx = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            wdog           <= '0;
            abort          <= 1'b0;
            bus.mult_reset <= 1'b0;
            bus.mult_start <= 1'b0;
            bus.mult_data  <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_prod   <= '0;
            bus.out_err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count          <= count + CW'(push) - CW'(pop);
            // Zero outside WAIT, so the first WAIT cycle always starts from 0
            wdog           <= (state == WAIT) ? wdog + 9'd1 : 9'd0;
            abort          <= timeout;
            bus.mult_reset <= mult_reset_nx;
            bus.mult_start <= mult_start_nx;
            bus.mult_data  <= mult_data_nx;
            bus.out_valid  <= out_valid_nx;
            bus.out_prod   <= out_prod_nx;
            bus.out_err    <= out_err_nx;
        end
    end
endmodule

// File: tb/tb_mult_operand_feeder.sv
// Bench for mult_operand_feeder: a behavioural multiplier, a queue-based
// expectation model checked every cycle, and directed literal checks.
module tb_mult_operand_feeder;
    localparam int W = 8, DEPTH = 2, TIMEOUT = 300, LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_operand_feeder_if #(.W(W)) bus();
    mult_operand_feeder #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [W-1:0]   a, b;
        logic [2*W-1:0] prod;
        logic           err;
    } exp_t;

    exp_t         exp_q[$];
    logic [2*W:0] got_q[$];
    int checks = 0, failures = 0, cyc = 0, start_count = 0, ldb_cyc = 0;
    bit hang = 0, ldb_seen = 0;
    logic [W-1:0] seen_a = '0, seen_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier stand-in: latches A then B after start, raises done LAT cycles later
    logic [2:0]     mp;
    logic [W-1:0]   ma, mb;
    int             lat;
    logic           done_m;
    logic [2*W-1:0] prod_m;
    assign bus.mult_done = done_m;
    assign bus.mult_prod = prod_m;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mp <= 3'd0; ma <= '0; mb <= '0; lat <= 0; done_m <= 1'b0; prod_m <= '0;
        end else if (bus.mult_reset) begin
            mp <= 3'd0; lat <= 0; done_m <= 1'b0; prod_m <= '0;
        end else begin
            case (mp)
                3'd0: if (bus.mult_start) mp <= 3'd1;
                3'd1: begin ma <= bus.mult_data; mp <= 3'd2; end
                3'd2: begin mb <= bus.mult_data; lat <= 0; prod_m <= 16'hA5A5; mp <= 3'd3; end
                3'd3: if (!hang) begin
                    if (lat == LAT) begin
                        prod_m <= 16'(ma) * 16'(mb);
                        done_m <= 1'b1;
                        mp     <= 3'd4;
                    end else lat <= lat + 1;
                end
                default: ;
            endcase
        end
    end

    // Compare process: bus ordering against the head pair, products against the queue
    initial begin
        bit pv = 0, pr = 0;
        logic [2*W:0] pw = '0;
        int bseq = 0;
        logic [W-1:0] ca = '0, cb = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin pv = 0; bseq = 0; continue; end
            if (bus.mult_start) start_count++;
            case (bseq)
                0: if (bus.mult_reset) begin
                    chk("bus_mrst_quiet", 32'({bus.mult_start, bus.mult_data}), 0);
                    if (exp_q.size() == 0) chk("bus_unexpected_mrst", 1, 0);
                    else begin
                        ca = exp_q[0].a; cb = exp_q[0].b;
                        chk("no_mult_for_zero", 32'(ca != 0 && cb != 0), 1);
                    end
                    bseq = 1;
                end else chk("bus_idle", 32'({bus.mult_start, bus.mult_data}), 0);
                1: begin
                    chk("bus_start", 32'({bus.mult_reset, bus.mult_start, bus.mult_data}),
                        32'({2'b01, {W{1'b0}}}));
                    bseq = 2;
                end
                2: begin
                    chk("bus_a", 32'({bus.mult_reset, bus.mult_start, bus.mult_data}), 32'({2'b00, ca}));
                    seen_a = bus.mult_data;
                    bseq = 3;
                end
                default: begin
                    chk("bus_b", 32'({bus.mult_reset, bus.mult_start, bus.mult_data}), 32'({2'b00, cb}));
                    seen_b = bus.mult_data;
                    ldb_cyc = cyc; ldb_seen = 1; bseq = 0;
                end
            endcase
            if (bus.out_valid) begin
                if (pv && !pr) chk("out_stable", 32'({bus.out_err, bus.out_prod}), 32'(pw));
                else if (exp_q.size() == 0) chk("unexpected_product", 1, 0);
                else begin
                    chk("out_prod", 32'(bus.out_prod), 32'(exp_q[0].prod));
                    chk("out_err", 32'(bus.out_err), 32'(exp_q[0].err));
                    if (exp_q[0].err) chk("abort_latency", cyc, ldb_cyc + TIMEOUT + 2);
                end
                if (bus.out_ready) begin
                    got_q.push_back({bus.out_err, bus.out_prod});
                    if (exp_q.size() != 0) exp_q.delete(0);
                end
            end
            pv = bus.out_valid; pr = bus.out_ready; pw = {bus.out_err, bus.out_prod};
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int k = 0;
        exp_t e;
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 400) begin @(posedge clk); #1; k++; end
        chk("push_accept", 32'(bus.in_ready), 1);
        if (!bus.in_ready) begin bus.in_valid = 1'b0; return; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        e.a = a; e.b = b;
        e.err  = (a != 0 && b != 0) && hang;
        e.prod = (a == 0 || b == 0 || e.err) ? '0 : 16'(a) * 16'(b);
        exp_q.push_back(e);
    endtask

    task automatic wait_products(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin @(posedge clk); k++; end
        #1;
        chk("products_arrived", 32'(got_q.size() >= n), 1);
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int base, sc0, k;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_prod", 32'(bus.out_prod), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        chk("rst_mult_bus", 32'({bus.mult_reset, bus.mult_start, bus.mult_data}), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        idle(2);

        // 8 x 9
        base = got_q.size();
        push(8'd8, 8'd9);
        wait_products(base + 1, 100);
        chk("lit_8x9", got_at(base), 72);
        chk("lit_bus_a", 32'(seen_a), 8);
        chk("lit_bus_b", 32'(seen_b), 9);
        idle(3);

        // zero bypass with timing from head-of-FIFO
        base = got_q.size(); sc0 = start_count;
        push(8'd0, 8'd200);
        chk("zero_t0_valid", 32'(bus.out_valid), 0);
        idle(1);
        chk("zero_t1_valid", 32'(bus.out_valid), 0);
        idle(1);
        chk("zero_t2_valid", 32'(bus.out_valid), 1);
        wait_products(base + 1, 20);
        push(8'd17, 8'd0);
        wait_products(base + 2, 20);
        chk("lit_zero_a", got_at(base), 0);
        chk("lit_zero_b", got_at(base + 1), 0);
        chk("zero_no_start", start_count, sc0);
        idle(3);

        // backpressure: one in HOLD, two queued
        base = got_q.size();
        bus.out_ready = 1'b0;
        push(8'd3, 8'd4);
        push(8'd5, 8'd6);
        push(8'd7, 8'd8);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        idle(5);
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("hold_prod", 32'(bus.out_prod), 12);
        chk("hold_in_ready", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        wait_products(base + 3, 200);
        chk("lit_bp0", got_at(base), 12);
        chk("lit_bp1", got_at(base + 1), 30);
        chk("lit_bp2", got_at(base + 2), 56);
        idle(3);

        // maximum operands
        base = got_q.size();
        push(8'd255, 8'd255);
        wait_products(base + 1, 100);
        chk("lit_max", got_at(base), 65025);
        idle(3);

        // watchdog abort, then a normal pair
        base = got_q.size();
        hang = 1;
        push(8'd6, 8'd7);
        wait_products(base + 1, TIMEOUT + 50);
        chk("lit_abort", got_at(base), 32'h1_0000);
        hang = 0;
        push(8'd2, 8'd3);
        wait_products(base + 2, 100);
        chk("lit_after_abort", got_at(base + 1), 6);
        idle(3);

        // reset while waiting with one pair queued
        hang = 1; ldb_seen = 0;
        push(8'd10, 8'd11);
        push(8'd12, 8'd13);
        k = 0;
        while (!ldb_seen && k < 50) begin idle(1); k++; end
        chk("reached_wait", 32'(ldb_seen), 1);
        idle(5);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_out_word", 32'({bus.out_err, bus.out_prod}), 0);
        chk("midrst_mult_bus", 32'({bus.mult_reset, bus.mult_start, bus.mult_data}), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        hang = 0;
        idle(2);
        #2 reset = 1'b1;
        base = got_q.size();
        idle(40);
        chk("midrst_no_product", got_q.size(), base);
        push(8'd4, 8'd5);
        wait_products(base + 1, 100);
        chk("lit_after_reset", got_at(base), 20);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
